ifetch_stage: RTL and testbench

Instruction fetch stage: owns the program counter, drives the combinational instruction memory address each cycle, and captures the returned instruction word plus any fetch exception into a 2-entry buffer. Entries go to decode over a valid/ready handshake. Branch, jump and trap targets enter through a redirect port that flushes the buffer. The block sits directly upstream of the instruction memory (address side) and directly upstream of decode (instruction side).

---
 rtl/ifetch_stage.sv | 141 ++++++++++++++
 tb/tb_ifetch_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// ifetch_stage
//   Instruction fetch stage. Owns the program counter, presents it to the
//   combinational instruction memory, and captures the returned word (or a
//   fetch exception) into a 2-entry buffer drained by decode over valid/ready.
//   A redirect reloads the PC, clears the halt state and flushes the buffer.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   redirect_en/_pc     load a new fetch target and flush the buffer
//   imem_addr           fetch address (always the current PC)
//   imem_instr          instruction word for imem_addr, same cycle
//   imem_exc_en/_code/_val  access fault for imem_addr, same cycle
//   out_valid/out_ready decode handshake
//   out_pc/_instr/_exc_en/_exc_code/_exc_val  head buffer entry
module ifetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc_en,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val
);

  logic [63:0] pc_q;
  logic        halt_q;
  logic [1:0]  count_q;
  logic        head_q;
  logic        tail_q;

  logic [63:0] ent_pc       [2];
  logic [31:0] ent_instr    [2];
  logic        ent_exc_en   [2];
  logic [3:0]  ent_exc_code [2];
  logic [63:0] ent_exc_val  [2];

  logic        pop;
  logic        push;
  logic        misaligned;
  logic        push_exc;
  logic [31:0] push_instr;
  logic [3:0]  push_code;
  logic [63:0] push_val;

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);

  always_comb begin
    pop  = out_valid & out_ready & ~redirect_en;
    // A full buffer may still accept when the head leaves in the same cycle.
    push = ~redirect_en & ~halt_q & ((count_q != 2'd2) | pop);

    // Misalignment outranks any fault reported by the memory.
    misaligned = (pc_q[1:0] != 2'b00);
    push_exc   = misaligned | imem_exc_en;
    push_instr = push_exc ? NOP_INSTR : imem_instr;
    push_code  = '0;
    push_val   = '0;
    if (misaligned) begin
      push_code = 4'd0;
      push_val  = pc_q;
    end else if (imem_exc_en) begin
      push_code = imem_exc_code;
      push_val  = imem_exc_val;
    end
  end

  always_comb begin
    out_pc       = '0;
    out_instr    = NOP_INSTR;
    out_exc_en   = 1'b0;
    out_exc_code = '0;
    out_exc_val  = '0;
    if (out_valid) begin
      out_pc       = ent_pc[head_q];
      out_instr    = ent_instr[head_q];
      out_exc_en   = ent_exc_en[head_q];
      out_exc_code = ent_exc_code[head_q];
      out_exc_val  = ent_exc_val[head_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      halt_q  <= 1'b0;
      count_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        ent_pc[i]       <= '0;
        ent_instr[i]    <= NOP_INSTR;
        ent_exc_en[i]   <= 1'b0;
        ent_exc_code[i] <= '0;
        ent_exc_val[i]  <= '0;
      end
    end else if (redirect_en) begin
      // Flush drops every entry, including a head being accepted this cycle.
      pc_q    <= redirect_pc;
      halt_q  <= 1'b0;
      count_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      if (pop) begin
        head_q <= ~head_q;
      end
      if (push) begin
        ent_pc[tail_q]       <= pc_q;
        ent_instr[tail_q]    <= push_instr;
        ent_exc_en[tail_q]   <= push_exc;
        ent_exc_code[tail_q] <= push_code;
        ent_exc_val[tail_q]  <= push_val;
        tail_q               <= ~tail_q;
        if (push_exc) begin
          halt_q <= 1'b1;
        end else begin
          pc_q <= pc_q + 64'd4;
        end
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
module tb_ifetch_stage;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  code;
    logic [63:0] val;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc_en;
  logic [3:0]  out_exc_code;
  logic [63:0] out_exc_val;

  // Memory model stimulus: word = 0x100 + address, fault at one chosen address.
  logic        flt_en;
  logic [63:0] flt_addr;
  logic [3:0]  flt_code;
  logic [63:0] flt_val;

  int n_checks = 0;
  int n_pass   = 0;
  entry_t sb[$];

  localparam logic [31:0] NOP = 32'h00000013;

  ifetch_stage #(.RESET_PC(64'h0), .NOP_INSTR(32'h00000013)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .imem_exc_en  (imem_exc_en),
    .imem_exc_code(imem_exc_code),
    .imem_exc_val (imem_exc_val),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_exc_en   (out_exc_en),
    .out_exc_code (out_exc_code),
    .out_exc_val  (out_exc_val)
  );

  always #5 clk = ~clk;

  always_comb begin
    imem_instr    = 32'h100 + imem_addr[31:0];
    imem_exc_en   = flt_en && (imem_addr == flt_addr);
    imem_exc_code = flt_code;
    imem_exc_val  = flt_val;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic expect_entry(input logic [63:0] pc, input logic [31:0] instr,
                              input logic exc_en, input logic [3:0] code,
                              input logic [63:0] val);
    entry_t e;
    e.pc = pc; e.instr = instr; e.exc_en = exc_en; e.code = code; e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_ok(input logic [63:0] pc);
    logic [31:0] w;
    w = 32'h100 + pc[31:0];
    expect_entry(pc, w, 1'b0, 4'd0, 64'd0);
  endtask

  // One cycle: sample at the falling edge, score any accepted head, then
  // advance past the rising edge. exp_valid: 0/1 checked, 2 = not checked.
  task automatic tick(input int exp_valid);
    entry_t e;
    @(negedge clk);
    if (exp_valid != 2) chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid == 1});
    if (out_valid && out_ready && !redirect_en) begin
      n_checks++;
      assert (sb.size() > 0) n_pass++;
      else $error("FAIL unexpected_entry observed pc=%h expected none", out_pc);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_pc",       out_pc,                 e.pc);
        chk("out_instr",    {32'd0, out_instr},     {32'd0, e.instr});
        chk("out_exc_en",   {63'd0, out_exc_en},    {63'd0, e.exc_en});
        chk("out_exc_code", {60'd0, out_exc_code},  {60'd0, e.code});
        chk("out_exc_val",  out_exc_val,            e.val);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [63:0] target, input int exp_valid);
    redirect_en = 1'b1;
    redirect_pc = target;
    tick(exp_valid);
    redirect_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; redirect_en = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    flt_en = 1'b0; flt_addr = '0; flt_code = '0; flt_val = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",    {63'd0, out_valid},    64'd0);
    chk("rst_pc",       out_pc,                64'd0);
    chk("rst_instr",    {32'd0, out_instr},    {32'd0, NOP});
    chk("rst_exc_en",   {63'd0, out_exc_en},   64'd0);
    chk("rst_exc_code", {60'd0, out_exc_code}, 64'd0);
    chk("rst_exc_val",  out_exc_val,           64'd0);
    chk("rst_imem",     imem_addr,             64'd0);

    // Free run: one entry per cycle from pc 0
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) expect_ok(64'(i * 4));
    for (int i = 0; i < 6; i++) tick(1);
    chk("freerun_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset mid-operation, then backpressure
    rst = 1'b0; #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_imem",  imem_addr,          64'd0);
    sb.delete();
    out_ready = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) tick(1);
    chk("bp_imem", imem_addr, 64'd8);
    chk("bp_head", out_pc,    64'd0);
    for (int i = 0; i < 5; i++) expect_ok(64'(i * 4));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick(1);
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Redirect with a full buffer while decode accepts the head
    out_ready = 1'b0;
    tick(1); tick(1);
    out_ready = 1'b1;
    redirect(64'h2000, 1);
    expect_ok(64'h2000); expect_ok(64'h2004); expect_ok(64'h2008);
    tick(0);
    for (int i = 0; i < 3; i++) tick(1);
    chk("redir_drained", 64'(sb.size()), 64'd0);

    // Access fault halts fetch until the next redirect
    flt_en = 1'b1; flt_addr = 64'h40000; flt_code = 4'd1; flt_val = 64'h40000;
    redirect(64'h40000, 1);
    expect_entry(64'h40000, NOP, 1'b1, 4'd1, 64'h40000);
    tick(0); tick(1);
    for (int i = 0; i < 3; i++) tick(0);
    chk("halt_imem", imem_addr, 64'h40000);
    redirect(64'h100, 0);
    expect_ok(64'h100); expect_ok(64'h104);
    tick(0); tick(1); tick(1);
    chk("resume_drained", 64'(sb.size()), 64'd0);

    // Misaligned target outranks a concurrent access fault
    flt_addr = 64'h1002; flt_code = 4'd5; flt_val = 64'hBEEF;
    redirect(64'h1002, 1);
    expect_entry(64'h1002, NOP, 1'b1, 4'd0, 64'h1002);
    tick(0); tick(1); tick(0); tick(0);
    chk("misalign_drained", 64'(sb.size()), 64'd0);

    // PC wraps past the top of the address space
    flt_en = 1'b0;
    redirect(64'hFFFF_FFFF_FFFF_FFFC, 0);
    expect_ok(64'hFFFF_FFFF_FFFF_FFFC); expect_ok(64'h0);
    tick(0); tick(1); tick(1);
    chk("wrap_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
